// File: rtl/ysyx_23060187_wbu_pkg.sv
// Shared definitions for the write-back unit: FSM encoding, load funct3 codes,
// and the legality rule for load width versus address alignment.
package ysyx_23060187_wbu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_WRITE,
        ST_FAULT
    } wbu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    // A load is legal only with a known width and a naturally aligned address.
    function automatic logic load_is_legal(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_LB, F3_LBU: load_is_legal = 1'b1;
            F3_LH, F3_LHU: load_is_legal = ~offset[0];
            F3_LW:         load_is_legal = (offset == 2'b00);
            default:       load_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060187_load_align.sv
// Combinational load data path: selects the addressed byte/half/word from the
// returned memory word and sign- or zero-extends it.
module ysyx_23060187_load_align
    import ysyx_23060187_wbu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_offset,
    input  logic [2:0]            i_funct3,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every signal driven here gets a value on every path; a missing
    // default in combinational logic infers a latch.
    always_comb begin
        w_byte = i_rdata[{i_offset, 3'b000} +: 8];
        w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
        case (i_funct3)
            F3_LB:   o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_LBU:  o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_LHU:  o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060187_wbu.sv
// Write-back unit: accepts one execute result, performs the load read if needed,
// and drives a single-cycle register file write with a wb_done pulse.
module ysyx_23060187_wbu
    import ysyx_23060187_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_rf_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [DATA_WIDTH-1:0] mem_araddr,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [1:0]            mem_rresp,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_done,
    output logic                  load_fault
);

    wbu_state_e            r_state;
    wbu_state_e            w_next;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_rf_wen;
    logic [2:0]            r_funct3;
    logic [1:0]            r_offset;

    logic                  w_accept;
    logic                  w_legal;
    logic                  w_rd_ok;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid & in_ready;
    assign w_legal  = load_is_legal(in_funct3, in_result[1:0]);
    assign w_rd_ok  = mem_rvalid & (mem_rresp == RRESP_OKAY);

    ysyx_23060187_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_rdata  (mem_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!in_is_load)  w_next = ST_WRITE;
                    else if (w_legal) w_next = ST_MEM_REQ;
                    else              w_next = ST_FAULT;
                end
            end
            ST_MEM_REQ:  if (mem_arready) w_next = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_rvalid)  w_next = w_rd_ok ? ST_WRITE : ST_FAULT;
            ST_WRITE,
            ST_FAULT:    w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Outputs are registered from the next state so each pulse lines up with
    // the cycle the FSM sits in WRITE/FAULT/MEM_REQ/MEM_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            mem_araddr  <= '0;
            rf_wen      <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            wb_done     <= 1'b0;
            load_fault  <= 1'b0;
            r_rd        <= '0;
            r_rf_wen    <= 1'b0;
            r_funct3    <= '0;
            r_offset    <= '0;
        end else begin
            mem_arvalid <= (w_next == ST_MEM_REQ);
            mem_rready  <= (w_next == ST_MEM_WAIT);
            wb_done     <= (w_next == ST_WRITE) || (w_next == ST_FAULT);
            load_fault  <= (w_next == ST_FAULT);
            rf_wen      <= 1'b0;

            if (w_accept) begin
                r_rd     <= in_rd;
                r_rf_wen <= in_rf_wen;
                r_funct3 <= in_funct3;
                r_offset <= in_result[1:0];
                if (in_is_load && w_legal)
                    mem_araddr <= {in_result[DATA_WIDTH-1:2], 2'b00};
                if (!in_is_load) begin
                    rf_wen   <= in_rf_wen && (in_rd != '0);
                    rf_waddr <= in_rd;
                    rf_wdata <= in_result;
                end
            end

            if ((r_state == ST_MEM_WAIT) && w_rd_ok) begin
                rf_wen   <= r_rf_wen && (r_rd != '0);
                rf_waddr <= r_rd;
                rf_wdata <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060187_wbu.sv
// Directed self-checking bench for the write-back unit; inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_ysyx_23060187_wbu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_result = '0;
    logic        in_rf_wen = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic        mem_arvalid;
    logic        mem_arready = 1'b0;
    logic [31:0] mem_araddr;
    logic        mem_rvalid = 1'b0;
    logic        mem_rready;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  mem_rresp = '0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_done;
    logic        load_fault;

    int n_pass  = 0;
    int n_total = 0;

    ysyx_23060187_wbu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_result(in_result),
        .in_rf_wen(in_rf_wen), .in_is_load(in_is_load), .in_funct3(in_funct3),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_done(wb_done), .load_fault(load_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single accepting edge; returns 1ns after it.
    task automatic issue(input logic [4:0] rd, input logic [31:0] res, input logic wen,
                         input logic ld, input logic [2:0] f3);
        in_valid = 1'b1; in_rd = rd; in_result = res;
        in_rf_wen = wen; in_is_load = ld; in_funct3 = f3;
        tick();
        in_valid = 1'b0;
    endtask

    // Issue a load and play the memory: AR stalls ar_delay cycles, R answers the
    // cycle after AR. Checks AR channel behaviour; returns in the WRITE/FAULT cycle.
    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic wen,
                           input logic [2:0] f3, input logic [31:0] rdata,
                           input logic [1:0] rresp, input int ar_delay, input string name);
        logic ok;
        ok = 1'b1;
        issue(rd, addr, wen, 1'b1, f3);
        for (int i = 0; i < ar_delay; i++) begin
            if (!(mem_arvalid === 1'b1 && mem_araddr === (addr & 32'hFFFF_FFFC))) ok = 1'b0;
            tick();
        end
        if (!(mem_arvalid === 1'b1 && mem_araddr === (addr & 32'hFFFF_FFFC))) ok = 1'b0;
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
        if (!(mem_arvalid === 1'b0 && mem_rready === 1'b1 && in_ready === 1'b0)) ok = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = rdata; mem_rresp = rresp;
        tick();
        mem_rvalid = 1'b0;
        n_total++;
        if (ok !== 1'b1)
            $display("FAIL %s ar_channel: arvalid=%b araddr=%h rready=%b expected araddr=%h",
                     name, mem_arvalid, mem_araddr, mem_rready, addr & 32'hFFFF_FFFC);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_total++;
        if ({in_ready, mem_arvalid, mem_rready, rf_wen, wb_done, load_fault} !== 6'b100000)
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {in_ready, mem_arvalid, mem_rready, rf_wen, wb_done, load_fault});
        else n_pass++;
        n_total++;
        if ({mem_araddr, rf_waddr, rf_wdata} !== 69'd0)
            $display("FAIL reset_data: araddr=%h waddr=%0d wdata=%h expected zeros",
                     mem_araddr, rf_waddr, rf_wdata);
        else n_pass++;
    endtask

    task automatic test_alu_write();
        issue(5'd5, 32'h1234_5678, 1'b1, 1'b0, 3'b000);
        n_total++;
        if ({rf_wen, wb_done, load_fault, in_ready} !== 4'b1100)
            $display("FAIL alu_ctrl: wen/done/fault/ready=%b expected 1100",
                     {rf_wen, wb_done, load_fault, in_ready});
        else n_pass++;
        n_total++;
        if (rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678)
            $display("FAIL alu_data: waddr=%0d wdata=%h expected 5 12345678", rf_waddr, rf_wdata);
        else n_pass++;
        tick();
        n_total++;
        if ({in_ready, rf_wen, wb_done} !== 3'b100)
            $display("FAIL alu_return: ready/wen/done=%b expected 100", {in_ready, rf_wen, wb_done});
        else n_pass++;
    endtask

    task automatic test_x0_suppress();
        issue(5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'b000);
        n_total++;
        if ({rf_wen, wb_done} !== 2'b01)
            $display("FAIL x0_suppress: wen/done=%b expected 01", {rf_wen, wb_done});
        else n_pass++;
        tick();
    endtask

    task automatic test_loads();
        // LB at offset 3 with a 2-cycle AR stall: byte 0x80 sign-extends.
        do_load(5'd3, 32'h8000_0003, 1'b1, 3'b000, 32'h80AA_BBCC, 2'b00, 2, "lb_off3");
        n_total++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hFFFF_FF80 || wb_done !== 1'b1)
            $display("FAIL lb_off3: wen=%b waddr=%0d wdata=%h expected 1 3 ffffff80",
                     rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        tick();

        do_load(5'd7, 32'h1000_0002, 1'b1, 3'b101, 32'h9ABC_1234, 2'b00, 0, "lhu_off2");
        n_total++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h0000_9ABC)
            $display("FAIL lhu_off2: wen=%b waddr=%0d wdata=%h expected 1 7 00009abc",
                     rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        tick();

        do_load(5'd8, 32'h1000_0002, 1'b1, 3'b001, 32'h9ABC_1234, 2'b00, 1, "lh_off2");
        n_total++;
        if (rf_wen !== 1'b1 || rf_wdata !== 32'hFFFF_9ABC)
            $display("FAIL lh_off2: wen=%b wdata=%h expected 1 ffff9abc", rf_wen, rf_wdata);
        else n_pass++;
        tick();

        do_load(5'd9, 32'h1000_0000, 1'b1, 3'b010, 32'hDEAD_BEEF, 2'b00, 0, "lw_off0");
        n_total++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hDEAD_BEEF)
            $display("FAIL lw_off0: wen=%b waddr=%0d wdata=%h expected 1 9 deadbeef",
                     rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        tick();

        do_load(5'd10, 32'h2000_0001, 1'b1, 3'b100, 32'h80AA_BBCC, 2'b00, 0, "lbu_off1");
        n_total++;
        if (rf_wen !== 1'b1 || rf_wdata !== 32'h0000_00BB)
            $display("FAIL lbu_off1: wen=%b wdata=%h expected 1 000000bb", rf_wen, rf_wdata);
        else n_pass++;
        tick();

        do_load(5'd11, 32'h2000_0000, 1'b1, 3'b000, 32'h1122_3344, 2'b00, 0, "lb_off0");
        n_total++;
        if (rf_wen !== 1'b1 || rf_wdata !== 32'h0000_0044)
            $display("FAIL lb_off0: wen=%b wdata=%h expected 1 00000044", rf_wen, rf_wdata);
        else n_pass++;
        tick();

        // Load with rf_wen=0 still reads memory but commits nothing.
        do_load(5'd12, 32'h2000_0004, 1'b0, 3'b010, 32'h5555_AAAA, 2'b00, 0, "lw_nowen");
        n_total++;
        if ({rf_wen, wb_done, load_fault} !== 3'b010)
            $display("FAIL lw_nowen: wen/done/fault=%b expected 010", {rf_wen, wb_done, load_fault});
        else n_pass++;
        tick();
    endtask

    task automatic test_faults();
        issue(5'd4, 32'h3000_0002, 1'b1, 1'b1, 3'b010);
        n_total++;
        if ({mem_arvalid, rf_wen, wb_done, load_fault, in_ready} !== 5'b00110)
            $display("FAIL lw_misaligned: arvalid/wen/done/fault/ready=%b expected 00110",
                     {mem_arvalid, rf_wen, wb_done, load_fault, in_ready});
        else n_pass++;
        tick();
        n_total++;
        if ({in_ready, wb_done, load_fault} !== 3'b100)
            $display("FAIL fault_return: ready/done/fault=%b expected 100",
                     {in_ready, wb_done, load_fault});
        else n_pass++;

        issue(5'd4, 32'h3000_0001, 1'b1, 1'b1, 3'b101);
        n_total++;
        if ({mem_arvalid, rf_wen, wb_done, load_fault} !== 4'b0011)
            $display("FAIL lhu_misaligned: arvalid/wen/done/fault=%b expected 0011",
                     {mem_arvalid, rf_wen, wb_done, load_fault});
        else n_pass++;
        tick();

        issue(5'd4, 32'h3000_0000, 1'b1, 1'b1, 3'b011);
        n_total++;
        if ({mem_arvalid, rf_wen, wb_done, load_fault} !== 4'b0011)
            $display("FAIL funct3_011: arvalid/wen/done/fault=%b expected 0011",
                     {mem_arvalid, rf_wen, wb_done, load_fault});
        else n_pass++;
        tick();

        do_load(5'd6, 32'h4000_0000, 1'b1, 3'b000, 32'h0000_00FF, 2'b10, 0, "lb_rresp");
        n_total++;
        if ({rf_wen, wb_done, load_fault} !== 3'b011)
            $display("FAIL lb_rresp: wen/done/fault=%b expected 011", {rf_wen, wb_done, load_fault});
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        issue(5'd1, 32'hAAAA_0001, 1'b1, 1'b0, 3'b000);
        // Keep a second instruction pending; it must wait for IDLE.
        in_valid = 1'b1; in_rd = 5'd2; in_result = 32'hBBBB_0002;
        in_rf_wen = 1'b1; in_is_load = 1'b0;
        n_total++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'hAAAA_0001)
            $display("FAIL b2b_first: wen=%b waddr=%0d wdata=%h expected 1 1 aaaa0001",
                     rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        tick();
        n_total++;
        if ({in_ready, rf_wen, wb_done} !== 3'b100)
            $display("FAIL b2b_gap: ready/wen/done=%b expected 100", {in_ready, rf_wen, wb_done});
        else n_pass++;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'hBBBB_0002 || wb_done !== 1'b1)
            $display("FAIL b2b_second: wen=%b waddr=%0d wdata=%h expected 1 2 bbbb0002",
                     rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_in_wait();
        issue(5'd13, 32'h5000_0000, 1'b1, 1'b1, 3'b010);
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
        n_total++;
        if (mem_rready !== 1'b1)
            $display("FAIL rst_wait_pre: rready=%b expected 1", mem_rready);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if ({in_ready, mem_arvalid, mem_rready, rf_wen, wb_done, load_fault} !== 6'b100000 ||
            {mem_araddr, rf_waddr, rf_wdata} !== 69'd0)
            $display("FAIL rst_wait_outputs: ctrl=%b araddr=%h waddr=%0d wdata=%h expected 100000 and zeros",
                     {in_ready, mem_arvalid, mem_rready, rf_wen, wb_done, load_fault},
                     mem_araddr, rf_waddr, rf_wdata);
        else n_pass++;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; mem_rresp = 2'b00;
        tick();
        mem_rvalid = 1'b0;
        tick();
        n_total++;
        if ({in_ready, rf_wen, wb_done, load_fault} !== 4'b1000)
            $display("FAIL rst_late_rvalid: ready/wen/done/fault=%b expected 1000",
                     {in_ready, rf_wen, wb_done, load_fault});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_x0_suppress();
        test_loads();
        test_faults();
        test_back_to_back();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
